// File: rtl/led_mode_ctrl_if.sv
// LED mode controller bus: board switch/button byte in, LED/status byte out.
interface led_mode_ctrl_if;
    logic [7:0] i_DATA;
    logic [7:0] o_DATA;

    modport master (output i_DATA, input o_DATA);
    modport slave  (input i_DATA, output o_DATA);
endinterface

// File: rtl/led_mode_ctrl.sv
// LED mode controller: OFF / steady ON / BLINK sequencing from a toggle
// button and mode switch, with a run-time programmable blink half-period.
module led_mode_ctrl #(
    parameter int CLK_DIV = 4,   // clock cycles per blink tick (>=1)
    parameter int CNT_W   = 16   // must hold 15*CLK_DIV
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    led_mode_ctrl_if.slave    bus
);

    // One-hot state; the 2-bit external code is decoded separately.
    localparam logic [3:0] S_OFF = 4'b0001;
    localparam logic [3:0] S_ON  = 4'b0010;
    localparam logic [3:0] S_BH  = 4'b0100;
    localparam logic [3:0] S_BL  = 4'b1000;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             t_d_q, t_d_d;

    logic             btn, mode, tog;
    logic [3:0]       hp;
    logic [CNT_W-1:0] hp_eff, lim_m1;
    logic             unused_bits;

    assign btn         = bus.i_DATA[0];
    assign mode        = bus.i_DATA[1];
    assign hp          = bus.i_DATA[7:4];
    assign unused_bits = ^bus.i_DATA[3:2];

    // Rising-edge detect on the button and the live half-period limit.
    always_comb begin
        t_d_d  = btn;
        tog    = btn & ~t_d_q;
        hp_eff = (hp == 4'd0) ? CNT_W'(1) : CNT_W'(hp);
        lim_m1 = hp_eff * CNT_W'(CLK_DIV) - CNT_W'(1);
    end

    // Next-state and phase counter; priority is tog > mode > timer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_OFF: begin
                cnt_d = '0;
                if (tog) state_d = mode ? S_BH : S_ON;
            end
            S_ON: begin
                cnt_d = '0;
                if (tog)       state_d = S_OFF;
                else if (mode) state_d = S_BH;
            end
            S_BH, S_BL: begin
                if (tog) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (!mode) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else if (cnt_q >= lim_m1) begin
                    // >= so a lowered half-period ends the phase at once
                    state_d = (state_q == S_BH) ? S_BL : S_BH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and button history; history tracks the button in reset
    // so a button held across reset release does not toggle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            t_d_q   <= btn;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_d_q   <= t_d_d;
        end
    end

    // Moore output decode from the state register only.
    assign bus.o_DATA = {4'b0000,
                         state_q[2] | state_q[3],   // code[1]
                         state_q[1] | state_q[3],   // code[0]
                         ~state_q[0],               // enabled
                         state_q[1] | state_q[2]};  // LED

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl: directed scenarios with fixed
// expected bytes, then randomized traffic against a behavioural model.
module tb_led_mode_ctrl;
    localparam int CLK_DIV = 4;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    led_mode_ctrl_if bus ();

    led_mode_ctrl #(.CLK_DIV(CLK_DIV), .CNT_W(16)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: is the LED enabled, is it blinking, which half,
    // and how many cycles the current half has lasted.
    bit m_en, m_blink, m_high, m_prev;
    int m_age;

    function automatic void model_update(input logic rst_n, input logic [7:0] din);
        bit tg;
        int lim;
        if (!rst_n) begin
            m_en = 0; m_blink = 0; m_high = 0; m_age = 0; m_prev = din[0];
            return;
        end
        tg     = din[0] && !m_prev;
        m_prev = din[0];
        lim    = ((din[7:4] == 0) ? 1 : int'(din[7:4])) * CLK_DIV;
        if (tg) begin
            m_en    = !m_en;
            m_blink = m_en && din[1];
            m_high  = 1;
            m_age   = 0;
        end else if (m_en) begin
            if (!m_blink && din[1]) begin
                m_blink = 1; m_high = 1; m_age = 0;
            end else if (m_blink && !din[1]) begin
                m_blink = 0; m_age = 0;
            end else if (m_blink) begin
                m_age++;
                if (m_age >= lim) begin
                    m_high = !m_high;
                    m_age  = 0;
                end
            end
        end
    endfunction

    function automatic logic [7:0] model_out();
        if (!m_en)   return 8'h00;
        if (!m_blink) return 8'h07;
        return m_high ? 8'h0B : 8'h0E;
    endfunction

    // One clock: drive away from the edge, advance model, settle past edge.
    task automatic step(input logic rst_n, input logic [7:0] din);
        @(negedge i_clk);
        i_rst_n    = rst_n;
        bus.i_DATA = din;
        @(posedge i_clk);
        model_update(rst_n, din);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 8'h01);
        step(1'b0, 8'h01);
        checks++;
        if (bus.o_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got %02h exp 00", bus.o_DATA);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h01);
            checks++;
            if (bus.o_DATA !== 8'h00) begin
                errors++;
                $display("FAIL held_button_after_reset cyc %0d got %02h exp 00", i, bus.o_DATA);
            end
        end
    endtask

    task automatic test_toggle_on_off();
        logic [7:0] din [6];
        logic [7:0] exp [6];
        din = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
        exp = '{8'h00, 8'h07, 8'h07, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, din[i]);
            checks++;
            if (bus.o_DATA !== exp[i]) begin
                errors++;
                $display("FAIL toggle_on_off step %0d got %02h exp %02h", i, bus.o_DATA, exp[i]);
            end
        end
    endtask

    task automatic test_blink_period();
        logic [7:0] exp;
        step(1'b1, 8'h22);
        checks++;
        if (bus.o_DATA !== 8'h00) begin
            errors++;
            $display("FAIL blink_mode_idle got %02h exp 00", bus.o_DATA);
        end
        for (int i = 0; i < 48; i++) begin
            step(1'b1, (i == 0) ? 8'h23 : 8'h22);
            exp = ((i % 16) < 8) ? 8'h0B : 8'h0E;
            checks++;
            if (bus.o_DATA !== exp) begin
                errors++;
                $display("FAIL blink_hp2 cyc %0d got %02h exp %02h", i, bus.o_DATA, exp);
            end
        end
        step(1'b1, 8'h23);
        checks++;
        if (bus.o_DATA !== 8'h00) begin
            errors++;
            $display("FAIL blink_toggle_off got %02h exp 00", bus.o_DATA);
        end
    endtask

    task automatic test_hp_zero();
        logic [7:0] exp;
        step(1'b1, 8'h02);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i == 0) ? 8'h03 : 8'h02);
            exp = ((i % 8) < 4) ? 8'h0B : 8'h0E;
            checks++;
            if (bus.o_DATA !== exp) begin
                errors++;
                $display("FAIL blink_hp0 cyc %0d got %02h exp %02h", i, bus.o_DATA, exp);
            end
        end
        step(1'b1, 8'h03);
        checks++;
        if (bus.o_DATA !== 8'h00) begin
            errors++;
            $display("FAIL hp0_toggle_off got %02h exp 00", bus.o_DATA);
        end
    endtask

    task automatic test_hp_shrink();
        logic [7:0] exp;
        step(1'b1, 8'hF2);
        step(1'b1, 8'hF3);
        for (int i = 0; i < 20; i++) step(1'b1, 8'hF2);
        checks++;
        if (bus.o_DATA !== 8'h0B) begin
            errors++;
            $display("FAIL hp15_high_at_cnt20 got %02h exp 0B", bus.o_DATA);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h12);
            exp = (i < 4) ? 8'h0E : 8'h0B;
            checks++;
            if (bus.o_DATA !== exp) begin
                errors++;
                $display("FAIL hp_shrink cyc %0d got %02h exp %02h", i, bus.o_DATA, exp);
            end
        end
    endtask

    task automatic test_mode_priority();
        logic [7:0] din [3];
        logic [7:0] exp [3];
        din = '{8'h10, 8'h13, 8'h12};
        exp = '{8'h07, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, din[i]);
            checks++;
            if (bus.o_DATA !== exp[i]) begin
                errors++;
                $display("FAIL mode_priority step %0d got %02h exp %02h", i, bus.o_DATA, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        logic [7:0] exp;
        step(1'b1, 8'h23);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h22);
        checks++;
        if (bus.o_DATA !== 8'h0B) begin
            errors++;
            $display("FAIL pre_reset_high got %02h exp 0B", bus.o_DATA);
        end
        step(1'b0, 8'h22);
        checks++;
        if (bus.o_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_blink got %02h exp 00", bus.o_DATA);
        end
        step(1'b1, 8'h22);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 0) ? 8'h23 : 8'h22);
            exp = (i < 8) ? 8'h0B : 8'h0E;
            checks++;
            if (bus.o_DATA !== exp) begin
                errors++;
                $display("FAIL restart_blink cyc %0d got %02h exp %02h", i, bus.o_DATA, exp);
            end
        end
    endtask

    task automatic test_random();
        logic       mode = 1'b0;
        logic [3:0] hp = 4'd2;
        logic       rst_n;
        logic [7:0] din, exp;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            if ($urandom_range(0, 19) == 0) hp = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 299) != 0);
            din   = {hp, 2'($urandom_range(0, 3)), mode, 1'($urandom_range(0, 7) == 0)};
            step(rst_n, din);
            exp = model_out();
            checks++;
            if (bus.o_DATA !== exp) begin
                errors++;
                $display("FAIL random cyc %0d in %02h rst_n %0b got %02h exp %02h",
                         i, din, rst_n, bus.o_DATA, exp);
            end
        end
    endtask

    initial begin
        bus.i_DATA = 8'h00;
        test_reset();
        test_toggle_on_off();
        test_blink_period();
        test_hp_zero();
        test_hp_shrink();
        test_mode_priority();
        test_reset_mid_blink();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
